demux_tdm_2x4: RTL
==================

// Module: demux_tdm_2x4
// PURPOSE
//   Receive-side counterpart of the 2-bit 4:1 mux: splits a time-division-multiplexed 2-bit stream
//   back into four 2-bit channels A..D. Slot 0 carries A, slot 1 B, slot 2 C, slot 3 D.
//   Slot 0 is marked by Frame_sync. Outputs update once per complete frame.
//   Sits between the TDM link and the per-channel consumers.
// PARAMETERS
//   DATA_W      2   width of each channel and of Din
//   SYNC_CHECK  1   1: a Frame_sync on a slot other than 0 flags Sync_err and realigns; 0: sync seen only in HUNT
// PORTS
//   Clk          in   1       single clock, rising edge
//   Rst          in   1       asynchronous, active-high reset
//   Din          in   DATA_W  TDM data beat
//   Din_valid    in   1       Din/Frame_sync qualified this cycle
//   Frame_sync   in   1       beat is slot 0 (valid only with Din_valid)
//   A_out        out  DATA_W  channel A (slot 0) of last complete frame
//   B_out        out  DATA_W  channel B (slot 1)
//   C_out        out  DATA_W  channel C (slot 2)
//   D_out        out  DATA_W  channel D (slot 3)
//   Frame_valid  out  1       1-cycle pulse: A..D_out just updated
//   Slot         out  2       slot index the next valid beat is written to (S1,S0 equivalent)
//   Locked       out  1       FSM in RUN
//   Sync_err     out  1       1-cycle pulse on misaligned Frame_sync
// BEHAVIOUR
//   Reset (async, Rst=1): all outputs 0, all capture registers 0, FSM=HUNT, Slot=0.
//   FSM HUNT: ignore beats until Din_valid&Frame_sync.
//     On that beat: capture Din into capture register 0, Slot<=1, go to RUN.
//   FSM RUN, beat with Din_valid=1:
//     - No sync, or sync with Slot==0: write capture[Slot]<=Din and Slot<=Slot+1 (wraps 3->0).
//     - Beat at Slot==3: on the next edge copy capture0..2 plus this Din to A..D_out together,
//       and pulse Frame_valid.
//     - Sync with Slot!=0 and SYNC_CHECK=1: discard the partial frame (outputs unchanged).
//       Write Din to capture0, Slot<=1, pulse Sync_err. Stay in RUN.
//     - Sync with Slot!=0 and SYNC_CHECK=0: the sync is ignored and the beat is taken as normal data.
//   Din_valid=0: stall. Slot, captures, outputs hold. Frame_sync is ignored.
//   Missing sync at slot 0 (Slot==0, no Frame_sync): accepted, no error. Locked stays 1.
//   Latency: last beat (slot 3) sampled at edge N; A..D_out and Frame_valid visible after edge N.
//     No stall cycle is needed between frames, so back-to-back frames give Frame_valid every 4th valid beat.
//   Frame_valid and Sync_err never assert together.
//   Reset mid-frame: partial frame lost, returns to HUNT, outputs cleared to 0.
//   Locked = (state==RUN), registered.
// STRUCTURE
//   demux_tdm_defs.vh holds: state encodings ST_HUNT=1'b0 and ST_RUN=1'b1,
//     slot constants SLOT_A..SLOT_D = 2'd0..2'd3, and the default DATA_W.
//   Sub-module demux_tdm_slot_ctr: 2-bit wrapping counter.
//     Inputs: inc, load1 (realign), async clear. Output: Slot.
//   The top level holds the FSM, four capture registers, four output registers, and the pulse flops.
// TESTING
//   T1 normal frame: reset, then valid beats 00(sync),01,10,11
//      -> one Frame_valid; A=00 B=01 C=10 D=11; Slot back to 0; Locked=1.
//   T2 hunt: beats 11,11 without sync, then frame 01(sync),00,11,10
//      -> no output change before sync; then A=01 B=00 C=11 D=10.
//   T3 stall: frame from T1 with Din_valid=0 for 3 cycles between slots 1 and 2
//      -> Frame_valid arrives 3 cycles later, same values; outputs and Slot hold during stall.
//   T4 realign (SYNC_CHECK=1): after 00(sync),01, send 11(sync),10,01,00
//      -> Sync_err pulse on the 11 beat; previous outputs unchanged; then A=11 B=10 C=01 D=00.
//   T5 back-to-back: two frames, no gaps
//      -> Frame_valid exactly 4 cycles apart; second frame values replace the first atomically.
//   T6 reset mid-frame: assert Rst after slot 2 beat
//      -> all outputs 0 immediately (async); Locked=0; next frame needs sync to lock.

Source files
------------

// File: rtl/demux_tdm_2x4_pkg.sv
// demux_tdm_2x4_pkg: shared state encodings, slot indices and default width for the TDM demux.
package demux_tdm_2x4_pkg;
    localparam int DATA_W_DEF = 2;
    typedef enum logic {ST_HUNT = 1'b0, ST_RUN = 1'b1} state_t;
    localparam logic [1:0] SLOT_A = 2'd0;
    localparam logic [1:0] SLOT_B = 2'd1;
    localparam logic [1:0] SLOT_C = 2'd2;
    localparam logic [1:0] SLOT_D = 2'd3;
endpackage

// File: rtl/demux_tdm_2x4_slot_ctr.sv
// demux_tdm_2x4_slot_ctr: 2-bit wrapping slot counter with realign load to slot 1.
import demux_tdm_2x4_pkg::*;

module demux_tdm_2x4_slot_ctr (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       i_inc,
    input  logic       i_load1,
    output logic [1:0] o_slot
);
    logic [1:0] r_slot;

    always_ff @(posedge Clk or posedge Rst)
        if (Rst)
            r_slot <= SLOT_A;
        else if (i_load1)
            r_slot <= SLOT_B;
        else if (i_inc)
            r_slot <= r_slot + 2'd1;

    assign o_slot = r_slot;
endmodule

// File: rtl/demux_tdm_2x4.sv
// demux_tdm_2x4: splits a framed 4-slot TDM stream into channels A..D, updating all four per complete frame.
import demux_tdm_2x4_pkg::*;

module demux_tdm_2x4 #(
    parameter int DATA_W     = DATA_W_DEF,
    parameter bit SYNC_CHECK = 1'b1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [DATA_W-1:0] Din,
    input  logic              Din_valid,
    input  logic              Frame_sync,
    output logic [DATA_W-1:0] A_out,
    output logic [DATA_W-1:0] B_out,
    output logic [DATA_W-1:0] C_out,
    output logic [DATA_W-1:0] D_out,
    output logic              Frame_valid,
    output logic [1:0]        Slot,
    output logic              Locked,
    output logic              Sync_err
);
    state_t            r_state, w_next;
    logic [DATA_W-1:0] r_cap [4];
    logic              w_start, w_realign, w_take, w_frame;

    demux_tdm_2x4_slot_ctr u_ctr (
        .Clk     (Clk),
        .Rst     (Rst),
        .i_inc   (w_take),
        .i_load1 (w_start | w_realign),
        .o_slot  (Slot)
    );

    always_ff @(posedge Clk or posedge Rst)
        if (Rst)
            r_state <= ST_HUNT;
        else
            r_state <= w_next;

    always_comb
        w_next = (r_state == ST_HUNT && Din_valid && Frame_sync) ? ST_RUN : r_state;

    always_comb begin
        w_start   = (r_state == ST_HUNT) && Din_valid && Frame_sync;
        w_realign = SYNC_CHECK && (r_state == ST_RUN) && Din_valid && Frame_sync && (Slot != SLOT_A);
        w_take    = (r_state == ST_RUN) && Din_valid && !w_realign;
        w_frame   = w_take && (Slot == SLOT_D);
    end

    // Slot D's beat goes straight to D_out so the whole frame lands on one edge.
    always_ff @(posedge Clk or posedge Rst)
        if (Rst) begin
            for (int i = 0; i < 4; i++)
                r_cap[i] <= '0;
            A_out       <= '0;
            B_out       <= '0;
            C_out       <= '0;
            D_out       <= '0;
            Frame_valid <= 1'b0;
            Sync_err    <= 1'b0;
        end else begin
            if (w_start || w_realign)
                r_cap[SLOT_A] <= Din;
            else if (w_take)
                r_cap[Slot] <= Din;
            if (w_frame) begin
                A_out <= r_cap[SLOT_A];
                B_out <= r_cap[SLOT_B];
                C_out <= r_cap[SLOT_C];
                D_out <= Din;
            end
            Frame_valid <= w_frame;
            Sync_err    <= w_realign;
        end

    assign Locked = (r_state == ST_RUN);
endmodule
